// File: rtl/imem_loader.sv
// imem_loader: byte-serial writer for the Y86-64 instruction memory.
//
// A program image arrives as a valid/ready byte stream and is stored from a
// chosen base address. While a load is in progress the pipeline is held. The
// fetch stage always sees a combinational FETCH_BYTES-wide window at f_pc.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_start        request a load (sampled only in idle)
//   load_base         first byte address of the image
//   load_len          image length in bytes, 1..MEM_BYTES
//   s_valid/s_data    incoming stream byte
//   s_ready           loader accepts a byte this cycle
//   load_busy         load in progress
//   load_done         one-cycle pulse after the last byte is written
//   load_err          sticky: the most recent load_start was rejected
//   cpu_hold          pipeline hold, covers the load and the done cycle
//   f_pc              fetch PC
//   f_window          bytes f_pc..f_pc+FETCH_BYTES-1, byte f_pc in the top byte
//   f_in_mem          set when f_pc lies beyond the memory (f_pc > MEM_BYTES-1)
//   load_csum         (IMEM_CHECKSUM_EN only) sum mod 256 of bytes in this load
//
// Optional feature: define IMEM_CHECKSUM_EN to add the load_csum output.

module imem_loader #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned FETCH_BYTES = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic [ADDR_W-1:0]        load_base,
  input  logic [ADDR_W:0]          load_len,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_err,
  output logic                     cpu_hold,
  input  logic [63:0]              f_pc,
  output logic [8*FETCH_BYTES-1:0] f_window,
`ifdef IMEM_CHECKSUM_EN
  output logic [7:0]               load_csum,
`endif
  output logic                     f_in_mem
);

  localparam logic [ADDR_W:0] MemBytesW = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   len_q;
  logic              s_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              hold_q;

  logic [7:0] mem [MEM_BYTES];

  logic            req_ok;
  logic [ADDR_W:0] req_end;
  logic            accept;
  logic            last_byte;

  // len is range-checked first, so base+len fits in ADDR_W+1 bits.
  assign req_end   = {1'b0, load_base} + load_len;
  assign req_ok    = (load_len != '0) && (load_len <= MemBytesW) && (req_end <= MemBytesW);
  assign accept    = s_ready_q && s_valid;
  assign last_byte = (count_q + (ADDR_W+1)'(1)) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      count_q   <= '0;
      len_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            if (req_ok) begin
              addr_q    <= load_base;
              len_q     <= load_len;
              count_q   <= '0;
              err_q     <= 1'b0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
              hold_q    <= 1'b1;
              state_q   <= StLoad;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            count_q <= count_q + (ADDR_W+1)'(1);
            if (last_byte) begin
              // Leave addr on the last written byte so it never passes the end.
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= StDone;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          hold_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory has no reset; contents survive a reset mid-load.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[addr_q] <= s_data;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
    end else if (state_q == StIdle && load_start && req_ok) begin
      csum_q <= 8'h00;
    end else if (accept) begin
      csum_q <= csum_q + s_data;
    end
  end

  assign load_csum = csum_q;
`endif

  // Fetch window: index computed at 65 bits so f_pc+i never wraps into memory.
  for (genvar g = 0; g < FETCH_BYTES; g++) begin : g_fetch
    logic [64:0] idx;
    assign idx = {1'b0, f_pc} + 65'(g);
    assign f_window[8*(FETCH_BYTES-1-g) +: 8] =
        (idx < 65'(MEM_BYTES)) ? mem[idx[ADDR_W-1:0]] : 8'h00;
  end

  assign f_in_mem  = (f_pc >= 64'(MEM_BYTES));
  assign s_ready   = s_ready_q;
  assign load_busy = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [9:0]  load_base;
  logic [10:0] load_len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic        cpu_hold;
  logic [63:0] f_pc;
  logic [79:0] f_window;
  logic        f_in_mem;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]  load_csum;
`endif

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .cpu_hold   (cpu_hold),
    .f_pc       (f_pc),
    .f_window   (f_window),
`ifdef IMEM_CHECKSUM_EN
    .load_csum  (load_csum),
`endif
    .f_in_mem   (f_in_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] tx_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted load with s_valid held high; bytes taken from tx_q, expectations
  // pushed to the scoreboard as each byte is driven.
  task automatic do_load(input logic [9:0] base, input logic [10:0] len, input string tag);
    logic [9:0] a;
    a          = base;
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check({tag, " busy"}, 80'(load_busy), 80'(1));
    check({tag, " hold"}, 80'(cpu_hold), 80'(1));
    for (int i = 0; i < int'(len); i++) begin
      s_valid = 1'b1;
      s_data  = tx_q.pop_front();
      sb_q.push_back('{addr: a, data: s_data});
      check($sformatf("%s ready%0d", tag, i), 80'(s_ready), 80'(1));
      check($sformatf("%s nodone%0d", tag, i), 80'(load_done), 80'(0));
      tick();
      a = a + 10'd1;
    end
    s_valid = 1'b0;
    check({tag, " done"}, 80'(load_done), 80'(1));
    check({tag, " ready_off"}, 80'(s_ready), 80'(0));
    check({tag, " hold_done"}, 80'(cpu_hold), 80'(1));
    tick();
    check({tag, " done_pulse"}, 80'(load_done), 80'(0));
    check({tag, " hold_off"}, 80'(cpu_hold), 80'(0));
  endtask

  task automatic drain_sb(input string tag);
    sb_t e;
    while (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      f_pc = 64'(e.addr);
      #1;
      check($sformatf("%s mem[%0d]", tag, e.addr), 80'(f_window[79:72]), 80'(e.data));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_base  = '0;
    load_len   = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    f_pc       = '0;
    #2;
    check("rst ready", 80'(s_ready), 80'(0));
    check("rst busy",  80'(load_busy), 80'(0));
    check("rst done",  80'(load_done), 80'(0));
    check("rst err",   80'(load_err), 80'(0));
    check("rst hold",  80'(cpu_hold), 80'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // T2/T4: load top of memory, then an overrun and a zero-length request
    tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(10'd1020, 11'd4, "t2a");
    drain_sb("t2a");
    load_base  = 10'd1020;
    load_len   = 11'd5;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t2 err_len5", 80'(load_err), 80'(1));
    check("t2 ready_len5", 80'(s_ready), 80'(0));
    check("t2 hold_len5", 80'(cpu_hold), 80'(0));
    tick();
    check("t2 err_sticky", 80'(load_err), 80'(1));
    load_base  = 10'd0;
    load_len   = 11'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t2 err_len0", 80'(load_err), 80'(1));
    check("t2 busy_len0", 80'(load_busy), 80'(0));

    f_pc = 64'd1020;
    #1;
    check("t4 window", f_window, {32'hAABBCCDD, 48'h0});
    check("t4 inmem_1020", 80'(f_in_mem), 80'(0));
    f_pc = 64'd1024;
    #1;
    check("t4 inmem_1024", 80'(f_in_mem), 80'(1));
    check("t4 window_1024", f_window, 80'h0);
    f_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("t4 window_wrap", f_window, 80'h0);

    // T1
    tx_q = '{8'h60, 8'h13};
    do_load(10'd0, 11'd2, "t1");
    check("t1 err_cleared", 80'(load_err), 80'(0));
    drain_sb("t1");
    f_pc = 64'd0;
    #1;
    check("t1 window", 80'(f_window[79:64]), 80'(16'h6013));

    // Same-cycle write and read of address 0
    load_base  = 10'd0;
    load_len   = 11'd1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    s_valid    = 1'b1;
    s_data     = 8'h77;
    f_pc       = 64'd0;
    #1;
    check("rw old", 80'(f_window[79:72]), 80'(8'h60));
    tick();
    s_valid = 1'b0;
    check("rw new", 80'(f_window[79:72]), 80'(8'h77));
    check("rw done", 80'(load_done), 80'(1));
    tick();

    // T3: throttled stream, valid pattern 1,0,0,1,1
    begin
      logic [4:0] pat;
      logic [7:0] b;
      logic [9:0] a;
      int         nw;
      pat        = 5'b11001;
      b          = 8'h11;
      a          = 10'd100;
      nw         = 0;
      load_base  = 10'd100;
      load_len   = 11'd3;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        s_valid = pat[i];
        s_data  = pat[i] ? b : 8'hEE;
        if (pat[i]) begin
          sb_q.push_back('{addr: a, data: b});
          a = a + 10'd1;
          b = b + 8'h11;
          nw++;
        end
        check($sformatf("t3 ready%0d", i), 80'(s_ready), 80'(1));
        tick();
        check($sformatf("t3 done%0d", i), 80'(load_done), 80'(nw == 3));
      end
      s_valid = 1'b0;
      tick();
      check("t3 idle", 80'(cpu_hold), 80'(0));
      drain_sb("t3");
      f_pc = 64'd100;
      #1;
      check("t3 window", 80'(f_window[79:56]), 80'(24'h112233));
    end

    // T5: reset after 2 of 5 bytes
    load_base  = 10'd200;
    load_len   = 11'd5;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    s_valid    = 1'b1;
    s_data     = 8'h9A;
    tick();
    s_data = 8'h9B;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 ready", 80'(s_ready), 80'(0));
    check("t5 busy", 80'(load_busy), 80'(0));
    check("t5 done", 80'(load_done), 80'(0));
    check("t5 err", 80'(load_err), 80'(0));
    check("t5 hold", 80'(cpu_hold), 80'(0));
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5 nodone%0d", i), 80'(load_done | s_ready), 80'(0));
    end
    f_pc = 64'd200;
    #1;
    check("t5 retained", 80'(f_window[79:64]), 80'(16'h9A9B));

`ifdef IMEM_CHECKSUM_EN
    check("t6 csum_rst", 80'(load_csum), 80'(0));
    load_base  = 10'd300;
    load_len   = 11'd3;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t6 csum_clr", 80'(load_csum), 80'(0));
    s_valid = 1'b1;
    s_data  = 8'hFF;
    tick();
    s_data = 8'h02;
    tick();
    s_data = 8'h10;
    tick();
    s_valid = 1'b0;
    check("t6 done", 80'(load_done), 80'(1));
    check("t6 csum", 80'(load_csum), 80'(8'h11));
    tick();
    check("t6 csum_hold", 80'(load_csum), 80'(8'h11));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
